reg_ctl: RTL and testbench

REG_CTL -- requirements
Module: reg_ctl

---
 rtl/reg_ctl.sv | 178 +++++++++++++++++
 tb/tb_reg_ctl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctl.sv
// SPI command parser driving the register file read and write ports.
// First byte of a frame is the command; following bytes are write payload or read clocks.
module reg_ctl #(
  parameter int RD_ADDR_MAX = 19
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_byte_vld_i,
  input  logic [7:0]  spi_byte_data_i,
  output logic [7:0]  spi_byte_data_o,
  output logic [4:0]  reg_rd_addr_o,
  input  logic [7:0]  reg_rd_data_i,
  output logic        reg_wr_en_o,
  output logic [2:0]  reg_wr_addr_o,
  output logic [95:0] reg_wr_data_o
);

  localparam logic [4:0] RD_MAX = 5'(RD_ADDR_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [2:0]  wr_addr_r;
  logic [95:0] wr_buf_r;
  logic [95:0] wr_buf_nxt_s;
  logic        rd_load_r;
  logic [3:0]  last_idx_s;
  logic        cmd_wr_s;
  logic        cmd_rd_s;
  logic        pay_s;
  logic        last_s;
  logic        rd_step_s;
  logic [4:0]  rd_start_s;
  logic [4:0]  rd_inc_s;

  // Next-state decode; a deselect overrides everything, including a coincident strobe.
  always_comb begin
    state_nxt_s = state_r;
    cmd_wr_s    = 1'b0;
    cmd_rd_s    = 1'b0;
    pay_s       = 1'b0;
    last_s      = 1'b0;
    rd_step_s   = 1'b0;
    if (wr_addr_r[2]) begin
      last_idx_s = 4'd11;
    end else begin
      last_idx_s = 4'd0;
    end
    if (spi_cs_n_i) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (spi_byte_vld_i) begin
            if (spi_byte_data_i[7]) begin
              cmd_wr_s    = 1'b1;
              state_nxt_s = WR_DATA;
            end else begin
              cmd_rd_s    = 1'b1;
              state_nxt_s = RD_DATA;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WR_DATA: begin
          if (spi_byte_vld_i) begin
            pay_s = 1'b1;
            if (cnt_r == last_idx_s) begin
              last_s      = 1'b1;
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = WR_DATA;
            end
          end else begin
            state_nxt_s = WR_DATA;
          end
        end
        RD_DATA: begin
          if (spi_byte_vld_i) begin
            rd_step_s = 1'b1;
          end else begin
            rd_step_s = 1'b0;
          end
        end
        HOLD: begin
          state_nxt_s = HOLD;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Payload merge into the shadow buffer and read address arithmetic.
  always_comb begin
    wr_buf_nxt_s = wr_buf_r;
    if (pay_s) begin
      wr_buf_nxt_s[{cnt_r, 3'b000} +: 8] = spi_byte_data_i;
    end else begin
      wr_buf_nxt_s = wr_buf_r;
    end
    if (spi_byte_data_i[4:0] > RD_MAX) begin
      rd_start_s = 5'd0;
    end else begin
      rd_start_s = spi_byte_data_i[4:0];
    end
    if (reg_rd_addr_o >= RD_MAX) begin
      rd_inc_s = 5'd0;
    end else begin
      rd_inc_s = reg_rd_addr_o + 5'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write path: payload collection, then a single strobe with the assembled word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r         <= 4'd0;
      wr_addr_r     <= 3'd0;
      wr_buf_r      <= 96'd0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= 3'd0;
      reg_wr_data_o <= 96'd0;
    end else begin
      reg_wr_en_o <= last_s;
      if (cmd_wr_s) begin
        wr_addr_r <= spi_byte_data_i[2:0];
        cnt_r     <= 4'd0;
        wr_buf_r  <= 96'd0;
      end else if (pay_s) begin
        wr_buf_r <= wr_buf_nxt_s;
        cnt_r    <= cnt_r + 4'd1;
      end
      if (last_s) begin
        reg_wr_addr_o <= wr_addr_r;
        reg_wr_data_o <= wr_buf_nxt_s;
      end
    end
  end

  // Read path: address updates one cycle after a strobe, output byte one cycle later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_rd_addr_o   <= 5'd0;
      rd_load_r       <= 1'b0;
      spi_byte_data_o <= 8'h00;
    end else begin
      rd_load_r <= cmd_rd_s | rd_step_s;
      if (cmd_rd_s) begin
        reg_rd_addr_o <= rd_start_s;
      end else if (rd_step_s) begin
        reg_rd_addr_o <= rd_inc_s;
      end
      if (rd_load_r) begin
        spi_byte_data_o <= reg_rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_reg_ctl.sv
// Directed bench for reg_ctl: write/read frames, aborts, clamping and asynchronous reset.
module tb_reg_ctl;

  logic        clk;
  logic        rst_n;
  logic        cs_n;
  logic        vld;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [95:0] wr_data;

  int compared = 0;
  int mismatched = 0;
  int pulses = 0;

  logic        wr_en_after;
  logic [4:0]  rd_addr_after;
  logic [7:0]  dout_after1;
  logic [7:0]  dout_after2;

  reg_ctl #(.RD_ADDR_MAX(19)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .spi_cs_n_i     (cs_n),
    .spi_byte_vld_i (vld),
    .spi_byte_data_i(din),
    .spi_byte_data_o(dout),
    .reg_rd_addr_o  (rd_addr),
    .reg_rd_data_i  (rd_data),
    .reg_wr_en_o    (wr_en),
    .reg_wr_addr_o  (wr_addr),
    .reg_wr_data_o  (wr_data)
  );

  // Register file read model: data = address XOR 8'hA5.
  assign rd_data = {3'b000, rd_addr} ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One strobe, then capture outputs 1 and 2 cycles after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    vld = 1'b1;
    din = b;
    @(posedge clk); #1;
    vld = 1'b0;
    wr_en_after   = wr_en;
    rd_addr_after = rd_addr;
    dout_after1   = dout;
    @(posedge clk); #1;
    dout_after2 = dout;
    @(posedge clk); #1;
  endtask

  task automatic deselect();
    @(posedge clk); #1;
    cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    vld   = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {95'd0, wr_en}, 96'd0);
    chk("rst_wr_addr", {93'd0, wr_addr}, 96'd0);
    chk("rst_wr_data", wr_data, 96'd0);
    chk("rst_rd_addr", {91'd0, rd_addr}, 96'd0);
    chk("rst_dout", {88'd0, dout}, 96'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cs_n = 1'b0;

    // Single-byte write to address 1
    send(8'h81);
    chk("w1_cmd_no_pulse", {95'd0, wr_en_after}, 96'd0);
    send(8'h5A);
    chk("w1_pulse", {95'd0, wr_en_after}, 96'd1);
    chk("w1_addr", {93'd0, wr_addr}, 96'd1);
    chk("w1_data", wr_data, 96'h5A);
    chk("w1_pulse_cnt", 96'(pulses), 96'd1);
    deselect();

    // Twelve-byte write to address 4
    send(8'h84);
    for (int i = 1; i <= 11; i++) send(8'(i));
    chk("w12_no_early_pulse", {95'd0, wr_en_after}, 96'd0);
    send(8'h0C);
    chk("w12_pulse", {95'd0, wr_en_after}, 96'd1);
    chk("w12_addr", {93'd0, wr_addr}, 96'd4);
    chk("w12_data", wr_data, 96'h0C0B0A09_08070605_04030201);
    chk("w12_pulse_cnt", 96'(pulses), 96'd2);
    deselect();

    // Write cut short by deselect, then a clean write to address 2
    send(8'h84);
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i));
    deselect();
    chk("abort_pulse_cnt", 96'(pulses), 96'd2);
    chk("abort_data_held", wr_data, 96'h0C0B0A09_08070605_04030201);
    chk("abort_addr_held", {93'd0, wr_addr}, 96'd4);
    send(8'h82);
    send(8'h33);
    chk("w2_addr", {93'd0, wr_addr}, 96'd2);
    chk("w2_data", wr_data, 96'h33);
    chk("w2_pulse_cnt", 96'(pulses), 96'd3);
    deselect();

    // Read from 18 with wrap past 19
    send(8'h12);
    chk("rd_addr_18", {91'd0, rd_addr_after}, 96'd18);
    chk("rd_dout_18", {88'd0, dout_after2}, 96'hB7);
    send(8'h00);
    chk("rd_addr_19", {91'd0, rd_addr_after}, 96'd19);
    chk("rd_dout_lat_hold", {88'd0, dout_after1}, 96'hB7);
    chk("rd_dout_19", {88'd0, dout_after2}, 96'hB6);
    send(8'h00);
    chk("rd_addr_wrap0", {91'd0, rd_addr_after}, 96'd0);
    chk("rd_dout_0", {88'd0, dout_after2}, 96'hA5);
    send(8'h00);
    chk("rd_addr_1", {91'd0, rd_addr_after}, 96'd1);
    chk("rd_dout_1", {88'd0, dout_after2}, 96'hA4);
    chk("rd_no_pulse", 96'(pulses), 96'd3);
    deselect();

    // Extra bytes after a complete write are ignored
    send(8'h80);
    send(8'hAA);
    chk("hold_pulse", {95'd0, wr_en_after}, 96'd1);
    send(8'hBB);
    chk("hold_no_pulse", {95'd0, wr_en_after}, 96'd0);
    chk("hold_data", wr_data, 96'hAA);
    chk("hold_addr", {93'd0, wr_addr}, 96'd0);
    chk("hold_pulse_cnt", 96'(pulses), 96'd4);
    deselect();

    // Start address above RD_ADDR_MAX clamps to 0
    send(8'h1F);
    chk("clamp_addr", {91'd0, rd_addr_after}, 96'd0);
    chk("clamp_dout", {88'd0, dout_after2}, 96'hA5);
    deselect();

    // Payload strobe coincident with deselect is discarded
    send(8'h83);
    cs_n = 1'b1;
    send(8'h77);
    chk("desel_win_no_pulse", {95'd0, wr_en_after}, 96'd0);
    chk("desel_win_cnt", 96'(pulses), 96'd4);
    cs_n = 1'b0;
    send(8'h83);
    send(8'h66);
    chk("w3_addr", {93'd0, wr_addr}, 96'd3);
    chk("w3_data", wr_data, 96'h66);
    chk("w3_pulse_cnt", 96'(pulses), 96'd5);
    deselect();

    // Asynchronous reset mid-read
    send(8'h05);
    chk("pre_rst_rd_addr", {91'd0, rd_addr_after}, 96'd5);
    chk("pre_rst_dout", {88'd0, dout_after2}, 96'hA0);
    send(8'h00);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_addr", {91'd0, rd_addr}, 96'd0);
    chk("arst_dout", {88'd0, dout}, 96'd0);
    chk("arst_wr_addr", {93'd0, wr_addr}, 96'd0);
    chk("arst_wr_data", wr_data, 96'd0);
    chk("arst_wr_en", {95'd0, wr_en}, 96'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h81);
    chk("post_rst_cmd_no_pulse", {95'd0, wr_en_after}, 96'd0);
    send(8'h44);
    chk("post_rst_pulse", {95'd0, wr_en_after}, 96'd1);
    chk("post_rst_addr", {93'd0, wr_addr}, 96'd1);
    chk("post_rst_data", wr_data, 96'h44);
    chk("post_rst_pulse_cnt", 96'(pulses), 96'd6);
    deselect();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
